// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch (I) and
// load/store (D) requesters. One requester is granted at a time. Its
// request is registered onto mem_* and held until mem_resp. The response
// and read data are then routed back to that requester. After every
// transaction the arbiter spends one IDLE cycle before the next grant.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_addr/i_rmask/i_wmask/i_wdata  I-side request (pending = any mask bit)
//   i_rdata/i_resp                I-side read data and completion pulse
//   d_*                           same set for the D requester
//   mem_addr/mem_rmask/mem_wmask/mem_wdata  registered memory request
//   mem_rdata/mem_resp            memory read data and completion pulse
//   busy                          serving either requester
//   grant_d                       serving the D requester
//
// Configuration
//   MEM_ARB_RR_EN  defined  : ties go to the side not granted last
//                  undefined: D wins ties, but I is forced after
//                             STARVE_LIMIT consecutive D grants while I waits
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_rmask,
  input  logic [DATA_W/8-1:0] i_wmask,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_rmask,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_rmask,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp,
  output logic                busy,
  output logic                grant_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   i_pend, d_pend, pick_i, grant_now;

  assign i_pend    = (|i_rmask) | (|i_wmask);
  assign d_pend    = (|d_rmask) | (|d_wmask);
  assign grant_now = (state == IDLE) && (i_pend || d_pend);

`ifdef MEM_ARB_RR_EN
  // 1 = D was granted last, 0 = I was granted last.
  logic rr_last_d;

  assign pick_i = i_pend && (!d_pend || rr_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_d <= 1'b0;
    end else if (grant_now) begin
      rr_last_d <= !pick_i;
    end
  end
`else
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign pick_i = i_pend && (!d_pend || (starve_cnt == CNT_W'(STARVE_LIMIT)));

  // Counts D grants made back-to-back while I waits; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_now) begin
      if (pick_i || !i_pend) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_pend || d_pend) state_nxt = pick_i ? SERVE_I : SERVE_D;
      SERVE_I,
      SERVE_D: if (mem_resp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture; masks drop together with the return to IDLE so memory
  // sees no request during the bubble cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_rmask <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else if (grant_now) begin
      mem_addr  <= pick_i ? i_addr  : d_addr;
      mem_rmask <= pick_i ? i_rmask : d_rmask;
      mem_wmask <= pick_i ? i_wmask : d_wmask;
      mem_wdata <= pick_i ? i_wdata : d_wdata;
    end else if ((state != IDLE) && mem_resp) begin
      mem_rmask <= '0;
      mem_wmask <= '0;
    end
  end

  always_comb begin
    i_resp  = (state == SERVE_I) && mem_resp;
    d_resp  = (state == SERVE_D) && mem_resp;
    i_rdata = i_resp ? mem_rdata : '0;
    d_rdata = d_resp ? mem_rdata : '0;
    busy    = (state != IDLE);
    grant_d = (state == SERVE_D);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  i_rmask, i_wmask, d_rmask, d_wmask;
  logic        i_resp, d_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        mem_resp, busy, grant_d;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_rmask(i_rmask), .i_wmask(i_wmask), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .grant_d(grant_d)
  );

  // Advance to the next cycle; inputs are driven right after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_addr = '0; i_rmask = '0; i_wmask = '0; i_wdata = '0;
    d_addr = '0; d_rmask = '0; d_wmask = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    #1;
    total++; if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== '0)
      $display("FAIL reset_mem: got %h/%h/%h/%h want all 0", mem_addr, mem_rmask, mem_wmask, mem_wdata);
    else passed++;
    total++; if ({busy, grant_d, i_resp, d_resp} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {busy, grant_d, i_resp, d_resp});
    else passed++;
    rst_n = 1'b1;
    step();
    d_addr = 32'h40; d_wmask = 4'hF; d_wdata = 32'h1234_5678;
    step();
    #1;
    total++; if (grant_d !== 1'b1 || mem_wmask !== 4'hF)
      $display("FAIL reset_pre_serve_d: got grant_d=%b wmask=%h want 1/f", grant_d, mem_wmask);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== '0 || busy !== 1'b0 || grant_d !== 1'b0)
      $display("FAIL reset_mid_serve: got addr=%h wmask=%h wdata=%h busy=%b grant_d=%b want 0", mem_addr, mem_wmask, mem_wdata, busy, grant_d);
    else passed++;
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
    mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (d_resp !== 1'b0 || i_resp !== 1'b0 || d_rdata !== 32'h0)
      $display("FAIL reset_stale_resp: got d_resp=%b i_resp=%b d_rdata=%h want 0/0/0", d_resp, i_resp, d_rdata);
    else passed++;
    step();
    mem_resp = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || mem_rmask !== 4'h0 || mem_wmask !== 4'h0)
      $display("FAIL reset_stays_idle: got busy=%b rmask=%h wmask=%h want 0", busy, mem_rmask, mem_wmask);
    else passed++;
  endtask

  task automatic test_lone_i_read();
    // cycle N
    i_addr = 32'h6000_0000; i_rmask = 4'hF;
    #1;
    total++; if (busy !== 1'b0)
      $display("FAIL lone_i_N_idle: got busy=%b want 0", busy);
    else passed++;
    for (int c = 1; c <= 2; c++) begin
      step();
      #1;
      total++; if (mem_addr !== 32'h6000_0000 || mem_rmask !== 4'hF || mem_wmask !== 4'h0 || i_resp !== 1'b0 || grant_d !== 1'b0)
        $display("FAIL lone_i_hold: cycle N+%0d got addr=%h rmask=%h wmask=%h i_resp=%b grant_d=%b want 60000000/f/0/0/0", c, mem_addr, mem_rmask, mem_wmask, i_resp, grant_d);
      else passed++;
    end
    step();
    mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
    #1;
    total++; if (mem_rmask !== 4'hF || i_resp !== 1'b1 || i_rdata !== 32'h13 || d_resp !== 1'b0 || d_rdata !== 32'h0)
      $display("FAIL lone_i_resp: got rmask=%h i_resp=%b i_rdata=%h d_resp=%b d_rdata=%h want f/1/13/0/0", mem_rmask, i_resp, i_rdata, d_resp, d_rdata);
    else passed++;
    step();
    mem_resp = 1'b0; i_rmask = 4'h0; i_addr = '0;
    #1;
    total++; if (busy !== 1'b0 || mem_rmask !== 4'h0 || i_resp !== 1'b0 || i_rdata !== 32'h0)
      $display("FAIL lone_i_after: got busy=%b rmask=%h i_resp=%b i_rdata=%h want 0/0/0/0", busy, mem_rmask, i_resp, i_rdata);
    else passed++;
    step();
  endtask

  task automatic test_tie();
    i_addr = 32'h200; i_rmask = 4'hF;
    d_addr = 32'h100; d_wmask = 4'h3; d_wdata = 32'hBEEF;
    step();
    #1;
    total++; if (grant_d !== 1'b1 || mem_addr !== 32'h100 || mem_wmask !== 4'h3 || mem_wdata !== 32'hBEEF || mem_rmask !== 4'h0)
      $display("FAIL tie_d_first: got grant_d=%b addr=%h wmask=%h wdata=%h rmask=%h want 1/100/3/beef/0", grant_d, mem_addr, mem_wmask, mem_wdata, mem_rmask);
    else passed++;
    // Requester inputs changing mid-serve must not reach memory.
    d_addr = 32'hFFFF_FFFF; d_wdata = 32'h0;
    step();
    mem_resp = 1'b1;
    #1;
    total++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hBEEF || d_resp !== 1'b1 || i_resp !== 1'b0)
      $display("FAIL tie_d_resp: got addr=%h wdata=%h d_resp=%b i_resp=%b want 100/beef/1/0", mem_addr, mem_wdata, d_resp, i_resp);
    else passed++;
    step();
    mem_resp = 1'b0; d_addr = '0; d_wmask = '0; d_wdata = '0;
    #1;
    total++; if (busy !== 1'b0 || mem_wmask !== 4'h0)
      $display("FAIL tie_bubble: got busy=%b wmask=%h want 0/0", busy, mem_wmask);
    else passed++;
    step();
    #1;
    total++; if (busy !== 1'b1 || grant_d !== 1'b0 || mem_addr !== 32'h200 || mem_rmask !== 4'hF)
      $display("FAIL tie_i_second: got busy=%b grant_d=%b addr=%h rmask=%h want 1/0/200/f", busy, grant_d, mem_addr, mem_rmask);
    else passed++;
    mem_resp = 1'b1; mem_rdata = 32'hCAFE_0001;
    #1;
    total++; if (i_resp !== 1'b1 || i_rdata !== 32'hCAFE_0001)
      $display("FAIL tie_i_resp: got i_resp=%b i_rdata=%h want 1/cafe0001", i_resp, i_rdata);
    else passed++;
    step();
    mem_resp = 1'b0; i_addr = '0; i_rmask = '0;
    step();
  endtask

  // Both sides keep requesting; record which side each of six grants goes to.
  task automatic test_back_to_back();
    logic [5:0] want_d;
    int unsigned waited;
`ifdef MEM_ARB_RR_EN
    want_d = 6'b010101; // bit k = grant k: D, I, D, I, D, I (I was granted last)
`else
    want_d = 6'b101111; // D x4, forced I, then D again
`endif
    i_addr = 32'h300; i_rmask = 4'hF;
    d_addr = 32'h400; d_rmask = 4'h1;
    for (int g = 0; g < 6; g++) begin
      waited = 0;
      step();
      while (busy !== 1'b1 && waited < 4) begin
        step();
        waited++;
      end
      total++; if (busy !== 1'b1) begin
        $display("FAIL b2b_grant_timeout: grant %0d got busy=%b want 1", g, busy);
      end else if (grant_d !== want_d[g] || waited != 0) begin
        $display("FAIL b2b_order: grant %0d got grant_d=%b after %0d extra cycles want %b after 0", g, grant_d, waited, want_d[g]);
      end else passed++;
      mem_resp = 1'b1; mem_rdata = 32'h100 + 32'(g);
      #1;
      total++; if (d_resp !== want_d[g] || i_resp !== !want_d[g])
        $display("FAIL b2b_resp: grant %0d got d_resp=%b i_resp=%b want %b/%b", g, d_resp, i_resp, want_d[g], !want_d[g]);
      else passed++;
      step();
      mem_resp = 1'b0;
      #1;
      total++; if (busy !== 1'b0)
        $display("FAIL b2b_bubble: grant %0d got busy=%b want 0", g, busy);
      else passed++;
    end
    clear_inputs();
    step();
  endtask

  task automatic test_spurious_resp();
    clear_inputs();
    mem_resp = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    total++; if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0)
      $display("FAIL spurious_resp: got i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h want 0", i_resp, d_resp, i_rdata, d_rdata);
    else passed++;
    step();
    mem_resp = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || grant_d !== 1'b0 || mem_rmask !== 4'h0 || mem_wmask !== 4'h0)
      $display("FAIL spurious_idle: got busy=%b grant_d=%b rmask=%h wmask=%h want 0", busy, grant_d, mem_rmask, mem_wmask);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_lone_i_read();
    test_tie();
    test_back_to_back();
    test_spurious_resp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
